// File: rtl/itrx_aib_phy_pkg.sv
// Shared types for the AIB PHY column redundancy/reset sequencer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
//
// Contents:
//   redn_ctl_state_t : sequencer state encoding
//   SPARE_IDX()      : index of the spare cell in a column of num_io cells
package itrx_aib_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_APPLY,
    ST_SETTLE,
    ST_REL_CORE,
    ST_REL_TX,
    ST_REL_RX,
    ST_RUN
  } redn_ctl_state_t;

  // The spare always sits at the top of the column.
  function automatic int SPARE_IDX(input int num_io);
    return num_io - 1;
  endfunction

endpackage

// File: rtl/itrx_aib_phy_redn_map.sv
// Thermometer decode of a repair request into the per-cell engage pattern.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_bad_en  : 1 = repair i_bad_idx, 0 = no repair (all-zero pattern)
//   i_bad_idx : index of the broken cell
//   o_pat     : engage pattern, bits i_bad_idx..NUM_IO-1 set when enabled
//   o_err     : enabled request naming the spare or an out-of-range cell
module itrx_aib_phy_redn_map
  import itrx_aib_phy_pkg::*;
#(
  parameter int NUM_IO = 20
) (
  input  logic                      i_bad_en,
  input  logic [$clog2(NUM_IO)-1:0] i_bad_idx,
  output logic [NUM_IO-1:0]         o_pat,
  output logic                      o_err
);

  always_comb begin
    o_pat = '0;
    o_err = i_bad_en && (int'(i_bad_idx) >= SPARE_IDX(NUM_IO));
    for (int i = 0; i < NUM_IO; i++) begin
      // Every cell from the broken one upward shifts over by one.
      if (i_bad_en && (i >= int'(i_bad_idx))) begin
        o_pat[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/itrx_aib_phy_redn_ctl.sv
// Redundancy and reset sequencer for one column of AIB IO cells.
// Latency: ack 1 cycle after a sampled request; full release 2*SETTLE_CYC+2*STEP_CYC+1 cycles after ack.
// Backpressure: cfg_req is only sampled when no sequence is running; requester holds it until cfg_ack.
//
// Ports:
//   clk, rst            : config clock, synchronous active-high reset
//   cfg_req/ack/err     : repair request handshake, err flags an illegal index
//   cfg_bad_en/idx      : repair target (en=0 clears all repair)
//   busy                : sequence in progress
//   redn_engage, prev_redn_engage, redn_any, spare_mode : per-cell redundancy controls
//   irstb, tx_irstb, rx_irstb : per-cell active-low resets, released core->TX->RX
module itrx_aib_phy_redn_ctl
  import itrx_aib_phy_pkg::*;
#(
  parameter int NUM_IO     = 20,
  parameter int SETTLE_CYC = 8,
  parameter int STEP_CYC   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_req,
  input  logic                      cfg_bad_en,
  input  logic [$clog2(NUM_IO)-1:0] cfg_bad_idx,
  output logic                      cfg_ack,
  output logic                      cfg_err,
  output logic                      busy,
  output logic [NUM_IO-1:0]         redn_engage,
  output logic [NUM_IO-1:0]         prev_redn_engage,
  output logic [NUM_IO-1:0]         redn_any,
  output logic [NUM_IO-1:0]         spare_mode,
  output logic [NUM_IO-1:0]         irstb,
  output logic [NUM_IO-1:0]         tx_irstb,
  output logic [NUM_IO-1:0]         rx_irstb
);

  localparam int MAX_CYC = (SETTLE_CYC > STEP_CYC) ? SETTLE_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_SETTLE   = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_STEP     = CNT_W'(STEP_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [NUM_IO-1:0] SPARE_ONEHOT = {1'b1, {(NUM_IO-1){1'b0}}};

  redn_ctl_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_IO-1:0] r_pat, w_pat_nxt;   // pattern latched at accept
  logic [NUM_IO-1:0] r_eng, w_eng_nxt;   // live engage register
  logic              r_ack, w_ack_nxt;
  logic              r_err, w_err_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_core_rel, w_core_rel_nxt;
  logic              r_tx_rel, w_tx_rel_nxt;
  logic              r_rx_rel, w_rx_rel_nxt;

  logic [NUM_IO-1:0] w_map_pat;
  logic              w_map_err;
  logic              w_cnt_last;

  itrx_aib_phy_redn_map #(
    .NUM_IO (NUM_IO)
  ) u_map (
    .i_bad_en  (cfg_bad_en),
    .i_bad_idx (cfg_bad_idx),
    .o_pat     (w_map_pat),
    .o_err     (w_map_err)
  );

  assign w_cnt_last = (r_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pat      <= '0;
      r_eng      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_core_rel <= 1'b0;
      r_tx_rel   <= 1'b0;
      r_rx_rel   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pat      <= w_pat_nxt;
      r_eng      <= w_eng_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_busy     <= w_busy_nxt;
      r_core_rel <= w_core_rel_nxt;
      r_tx_rel   <= w_tx_rel_nxt;
      r_rx_rel   <= w_rx_rel_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pat_nxt      = r_pat;
    w_eng_nxt      = r_eng;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_busy_nxt     = r_busy;
    w_core_rel_nxt = r_core_rel;
    w_tx_rel_nxt   = r_tx_rel;
    w_rx_rel_nxt   = r_rx_rel;

    case (r_state)
      // REL_RX is the first released cycle: RX is already out of reset and
      // busy is low, so it takes a held request exactly like RUN. That lets a
      // request that waited through the sequence be accepted one cycle after
      // rx_irstb rises.
      ST_IDLE, ST_RUN, ST_REL_RX: begin
        if (r_state == ST_REL_RX) begin
          w_state_nxt = ST_RUN;
        end
        if (cfg_req) begin
          w_ack_nxt = 1'b1;
          if (w_map_err) begin
            w_err_nxt = 1'b1;
          end else begin
            // Latch the target now; the requester may drop its inputs after ack.
            w_state_nxt    = ST_QUIESCE;
            w_cnt_nxt      = CNT_SETTLE;
            w_pat_nxt      = w_map_pat;
            w_busy_nxt     = 1'b1;
            w_core_rel_nxt = 1'b0;
            w_tx_rel_nxt   = 1'b0;
            w_rx_rel_nxt   = 1'b0;
          end
        end
      end

      ST_QUIESCE: begin
        if (w_cnt_last) begin
          // Engage loads on APPLY entry so the new pattern is stable for the
          // whole APPLY cycle and every SETTLE cycle, with resets still held.
          w_state_nxt = ST_APPLY;
          w_cnt_nxt   = CNT_ONE;
          w_eng_nxt   = r_pat;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      ST_APPLY: begin
        w_state_nxt = ST_SETTLE;
        w_cnt_nxt   = CNT_SETTLE;
      end

      ST_SETTLE: begin
        if (w_cnt_last) begin
          w_state_nxt    = ST_REL_CORE;
          w_cnt_nxt      = CNT_STEP;
          w_core_rel_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      ST_REL_CORE: begin
        if (w_cnt_last) begin
          w_state_nxt  = ST_REL_TX;
          w_cnt_nxt    = CNT_STEP;
          w_tx_rel_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      ST_REL_TX: begin
        if (w_cnt_last) begin
          w_state_nxt  = ST_REL_RX;
          w_cnt_nxt    = CNT_ONE;
          w_rx_rel_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cfg_ack          = r_ack;
  assign cfg_err          = r_err;
  assign busy             = r_busy;
  assign redn_engage      = r_eng;
  assign prev_redn_engage = {r_eng[NUM_IO-2:0], 1'b0};
  assign redn_any         = {NUM_IO{|r_eng}};
  assign spare_mode       = SPARE_ONEHOT;
  assign irstb            = {NUM_IO{r_core_rel}};
  assign tx_irstb         = {NUM_IO{r_tx_rel}};
  assign rx_irstb         = {NUM_IO{r_rx_rel}};

endmodule
